// File: rtl/hcsr04_emulator.sv
// hcsr04_emulator: cycle-accurate emulation of an HC-SR04 ultrasonic ranging
// sensor as seen from its controller. A trigger pulse of at least
// TRIG_MIN_CYC cycles starts a measurement. After a burst delay the block
// returns an echo pulse whose width encodes the emulated distance. A hold-off
// period follows, during which triggers are ignored.
//
// Optional feature: define HCSR04_EMU_NOISE_EN to add 0..7 cycles of
// pseudo-random jitter, taken from a 16-bit LFSR, to every echo width.
// The parameters are expected to be >= 1.
module hcsr04_emulator #(
    parameter int unsigned TRIG_MIN_CYC = 500,
    parameter int unsigned BURST_CYC    = 10000,
    parameter int unsigned ECHO_MAX_CYC = 1900000,
    parameter int unsigned HOLDOFF_CYC  = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_i,
    input  logic [31:0] echo_cycles_i,
    output logic        echo_o,
    output logic        busy_o,
    output logic        echo_done_o,
    output logic        short_trig_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam logic [31:0] TRIG_MIN_W   = 32'(TRIG_MIN_CYC);
    localparam logic [31:0] BURST_LAST   = 32'(BURST_CYC) - 32'd1;
    localparam logic [31:0] ECHO_MAX_W   = 32'(ECHO_MAX_CYC);
    localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYC) - 32'd1;

    // Requested widths of zero (no object) or beyond range clamp to the maximum
    function automatic logic [31:0] clamp_width(input logic [31:0] req);
        logic [31:0] w;
        w = req;
        if ((req == 32'd0) || (req > ECHO_MAX_W)) begin
            w = ECHO_MAX_W;
        end
        return w;
    endfunction

    logic        trig_meta_q;
    logic        trig_s_q;
    logic        trig_prev_q;
    logic        trig_rise;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] w_q, w_d;
    logic        echo_q, echo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic [31:0] width_next;

    // Two-flop synchronizer for the asynchronous trigger, plus one delay stage
    // so a rising edge of the synchronized trigger can be detected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta_q <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            trig_meta_q <= trig_i;
            trig_s_q    <= trig_meta_q;
            trig_prev_q <= trig_s_q;
        end
    end

    // A level still high from before IDLE is not a rising edge, so a held
    // trigger cannot restart a measurement
    assign trig_rise = trig_s_q & ~trig_prev_q;

`ifdef HCSR04_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0 every cycle
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
    end

    // LFSR state register; reset seed is nonzero so the sequence never locks up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Jitter is added after clamping, so the maximum width can grow by up to 7
    always_comb begin
        width_next = clamp_width(echo_cycles_i) + {29'd0, lfsr_q[2:0]};
    end
`else
    // Echo width is exactly the clamped request
    always_comb begin
        width_next = clamp_width(echo_cycles_i);
    end
`endif

    // Measurement sequencer: next state, shared counter, latched width, and
    // registered outputs that are derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        short_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trig_rise) begin
                    state_d = S_TRIG;
                    cnt_d   = 32'd1;
                end
            end

            S_TRIG: begin
                if (trig_s_q) begin
                    // Saturate so an arbitrarily long trigger cannot wrap
                    if (cnt_q < TRIG_MIN_W) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (cnt_q >= TRIG_MIN_W) begin
                    state_d = S_BURST;
                    cnt_d   = 32'd0;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                    short_d = 1'b1;
                end
            end

            S_BURST: begin
                if (cnt_q >= BURST_LAST) begin
                    state_d = S_ECHO;
                    cnt_d   = 32'd0;
                    // Width is captured once; later input changes do not
                    // disturb the pulse in flight
                    w_d     = width_next;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_ECHO: begin
                // w_q is never zero, so the subtraction cannot underflow
                if (cnt_q >= (w_q - 32'd1)) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = 32'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_HOLDOFF: begin
                if (cnt_q >= HOLDOFF_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        echo_d = (state_d == S_ECHO);
        busy_d = (state_d == S_BURST) || (state_d == S_ECHO) ||
                 (state_d == S_HOLDOFF);
    end

    // State, counter, width and output registers; reset clears everything,
    // including an echo pulse in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            w_q     <= 32'd0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end

    assign echo_o       = echo_q;
    assign busy_o       = busy_q;
    assign echo_done_o  = done_q;
    assign short_trig_o = short_q;

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Testbench for hcsr04_emulator with small timing parameters. Randomized
// trigger widths and echo requests are checked against a transaction-level
// timing model built from the sensor's rules.
module tb_hcsr04_emulator;

    localparam int TRIG_MIN = 5;
    localparam int BURST    = 8;
    localparam int EMAX     = 100;
    localparam int HOLD     = 20;
    localparam int SYNC     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_i;
    logic [31:0] echo_cycles_i;
    logic        echo_o;
    logic        busy_o;
    logic        echo_done_o;
    logic        short_trig_o;

    always #5 clk = ~clk;

    hcsr04_emulator #(
        .TRIG_MIN_CYC(TRIG_MIN),
        .BURST_CYC   (BURST),
        .ECHO_MAX_CYC(EMAX),
        .HOLDOFF_CYC (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig_i       (trig_i),
        .echo_cycles_i(echo_cycles_i),
        .echo_o       (echo_o),
        .busy_o       (busy_o),
        .echo_done_o  (echo_done_o),
        .short_trig_o (short_trig_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // observed event log, rebuilt every sampled cycle
    int   echo_rises, echo_rise_cyc, echo_fall_cyc;
    int   done_cnt, done_cyc, short_cnt, short_cyc;
    int   busy_rises, busy_rise_cyc, busy_fall_cyc;
    logic echo_prev, busy_prev, echo_fell, busy_fell;
    int   noise_at_rise;
    int   noise_prev;

`ifdef HCSR04_EMU_NOISE_EN
    logic [15:0] lfsr_m;
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] b;
        b = 16'((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001);
        return (l >> 1) | (b << 15);
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        echo_rises = 0; echo_rise_cyc = -1; echo_fall_cyc = -1;
        done_cnt = 0; done_cyc = -1; short_cnt = 0; short_cyc = -1;
        busy_rises = 0; busy_rise_cyc = -1; busy_fall_cyc = -1;
        echo_fell = 1'b0; busy_fell = 1'b0; noise_at_rise = 0;
        echo_prev = echo_o; busy_prev = busy_o;
    endtask

    // advance one clock and log output events for that cycle
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
`ifdef HCSR04_EMU_NOISE_EN
        if (rst) lfsr_m = 16'hACE1;
        else     lfsr_m = lfsr_step(lfsr_m);
`endif
        if (echo_o && !echo_prev) begin
            echo_rises++; echo_rise_cyc = cyc; noise_at_rise = noise_prev;
        end
        if (!echo_o && echo_prev) begin echo_fall_cyc = cyc; echo_fell = 1'b1; end
        if (busy_o && !busy_prev) begin busy_rises++; busy_rise_cyc = cyc; end
        if (!busy_o && busy_prev) begin busy_fall_cyc = cyc; busy_fell = 1'b1; end
        if (echo_done_o) begin done_cnt++; done_cyc = cyc; end
        if (short_trig_o) begin short_cnt++; short_cyc = cyc; end
        echo_prev = echo_o;
        busy_prev = busy_o;
`ifdef HCSR04_EMU_NOISE_EN
        noise_prev = int'(lfsr_m[2:0]);
`else
        noise_prev = 0;
`endif
    endtask

    function automatic int model_w(input logic [31:0] v);
        if (v == 0 || v > EMAX) return EMAX;
        return int'(v);
    endfunction

    // check one measurement started at cycle t0 with a trigger n cycles wide
    task automatic check_measure(input string tag, input int t0, input int n, input int w);
        int burst_start, echo_start, echo_end;
        burst_start = t0 + SYNC + n + 1;   // first cycle after synced trigger falls
        echo_start  = burst_start + BURST;
        echo_end    = echo_start + w;
        chk({tag, "_echo_rises"}, echo_rises, 1);
        chk({tag, "_echo_rise"}, echo_rise_cyc, echo_start);
        chk({tag, "_echo_width"}, echo_fall_cyc - echo_rise_cyc, w);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, echo_end);
        chk({tag, "_busy_rise"}, busy_rise_cyc, burst_start);
        chk({tag, "_busy_fall"}, busy_fall_cyc, echo_end + HOLD);
        chk({tag, "_short_cnt"}, short_cnt, 0);
    endtask

    task automatic run_trig(input int n, input logic [31:0] val);
        int t0, k, w;
        clear_mon();
        echo_cycles_i = val;
        trig_i = 1'b1;
        t0 = cyc;
        repeat (n) step();
        trig_i = 1'b0;
        if (n >= TRIG_MIN) begin
            k = 0;
            while (!busy_fell && k < 400) begin step(); k++; end
            chk("measure_timeout", busy_fell, 1);
            w = model_w(val) + noise_at_rise;
`ifdef HCSR04_EMU_NOISE_EN
            chk("noise_range", (w >= model_w(val)) && (w <= model_w(val) + 7), 1);
`endif
            check_measure("meas", t0, n, w);
        end else begin
            repeat (10) step();
            chk("short_cnt", short_cnt, 1);
            chk("short_cyc", short_cyc, t0 + SYNC + n + 1);
            chk("short_echo", echo_rises, 0);
            chk("short_busy", busy_rises, 0);
        end
        repeat (3) step();
    endtask

    // retriggers during ECHO and a trigger held past HOLDOFF must be ignored
    task automatic run_ignore();
        int t0, k, w;
        clear_mon();
        echo_cycles_i = 32'd30;
        trig_i = 1'b1;
        t0 = cyc;
        repeat (5) step();
        trig_i = 1'b0;
        k = 0;
        while (echo_rises == 0 && k < 100) begin step(); k++; end
        chk("ign_rise_timeout", echo_rises, 1);
        repeat (5) step();
        trig_i = 1'b1;
        repeat (6) step();
        trig_i = 1'b0;
        echo_cycles_i = 32'd77;
        k = 0;
        while (!echo_fell && k < 200) begin step(); k++; end
        trig_i = 1'b1;
        k = 0;
        while (!busy_fell && k < 200) begin step(); k++; end
        chk("ign_busy_timeout", busy_fell, 1);
        repeat (15) step();
        trig_i = 1'b0;
        repeat (5) step();
        w = 30 + noise_at_rise;
        check_measure("ign", t0, 5, w);
        chk("ign_busy_rises", busy_rises, 1);
    endtask

    task automatic run_reset_mid_echo();
        int k;
        clear_mon();
        echo_cycles_i = 32'd50;
        trig_i = 1'b1;
        repeat (5) step();
        trig_i = 1'b0;
        k = 0;
        while (echo_rises == 0 && k < 100) begin step(); k++; end
        chk("rst_rise_timeout", echo_rises, 1);
        repeat (9) step();
        chk("rst_pre_echo", echo_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_echo", echo_o, 0);
        chk("rst_async_busy", busy_o, 0);
        chk("rst_async_done", echo_done_o, 0);
        chk("rst_async_short", short_trig_o, 0);
        repeat (2) step();
        rst = 1'b0;
        clear_mon();
        repeat (30) step();
        chk("rst_after_echo", echo_rises, 0);
        chk("rst_after_busy", busy_rises, 0);
        chk("rst_after_short", short_cnt, 0);
    endtask

    initial begin
        logic [31:0] val;
        int n, r;
        rst = 1'b1;
        trig_i = 1'b0;
        echo_cycles_i = 32'd0;
        noise_prev = 0;
`ifdef HCSR04_EMU_NOISE_EN
        lfsr_m = 16'hACE1;
`endif
        clear_mon();
        repeat (3) step();
        chk("reset_echo", echo_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", echo_done_o, 0);
        chk("reset_short", short_trig_o, 0);
        rst = 1'b0;
        repeat (4) step();

        // directed: nominal, short, clamp cases, edge widths
        run_trig(5, 32'd40);
        run_trig(4, 32'd40);
        run_trig(5, 32'd0);
        run_trig(5, 32'd500);
        run_trig(6, 32'd100);
        run_trig(5, 32'd101);
        run_trig(9, 32'd1);
        run_trig(1, 32'd10);
        run_trig(5, 32'hFFFF_FFFF);

        run_ignore();
        run_trig(5, 32'd40);

        run_reset_mid_echo();
        run_trig(5, 32'd40);

        // randomized trigger widths and echo requests
        for (int i = 0; i < 14; i++) begin
            n = $urandom_range(1, 9);
            r = $urandom_range(0, 9);
            case (r)
                0:       val = 32'd0;
                1:       val = 32'(EMAX);
                2:       val = 32'(EMAX + 1);
                3:       val = $urandom;
                default: val = 32'($urandom_range(1, EMAX));
            endcase
            run_trig(n, val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/hcsr04_emulator.md
HCSR04_EMULATOR -- requirements
Module: hcsr04_emulator

Interface
REQ-001 SHALL have parameter TRIG_MIN_CYC, default 500; minimum accepted trigger high width in clk cycles (10 us at 50 MHz).
REQ-002 SHALL have parameter BURST_CYC, default 10000; delay from accepted trigger fall to echo rise in cycles (200 us).
REQ-003 SHALL have parameter ECHO_MAX_CYC, default 1900000; no-object / clamp echo width in cycles (38 ms).
REQ-004 SHALL have parameter HOLDOFF_CYC, default 3000000; dead time after echo fall in cycles (60 ms).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port trig_i  input  1  asynchronous trigger from the ultrasonic controller.
REQ-008 SHALL have port echo_cycles_i  input  32  requested echo width in clk cycles (emulated distance).
REQ-009 SHALL have port echo_o  output  1  emulated echo pulse to the controller.
REQ-010 SHALL have port busy_o  output  1  high in BURST, ECHO and HOLDOFF.
REQ-011 SHALL have port echo_done_o  output  1  one-cycle pulse on echo completion.
REQ-012 SHALL have port short_trig_o  output  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYC is rejected.

Function
REQ-013 SHALL synchronize trig_i through a 2-flop synchronizer; trig_s denotes its output, and all timing below is referenced to trig_s.
REQ-014 SHALL implement states IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-015 IDLE: on trig_s rising (low previous cycle, high now) SHALL go to TRIG with width counter = 1.
REQ-016 TRIG: counter SHALL increment each cycle trig_s is high, saturating at TRIG_MIN_CYC.
REQ-017 TRIG: on trig_s low, if counter >= TRIG_MIN_CYC SHALL go to BURST; otherwise SHALL go to IDLE and pulse short_trig_o for exactly 1 cycle.
REQ-018 BURST SHALL last exactly BURST_CYC cycles, then go to ECHO.
REQ-019 On the BURST->ECHO transition SHALL latch W = echo_cycles_i; if echo_cycles_i == 0 or > ECHO_MAX_CYC, W = ECHO_MAX_CYC.
REQ-020 echo_o SHALL be registered and high for exactly W consecutive cycles, starting the first cycle in ECHO.
REQ-021 On echo_o fall SHALL enter HOLDOFF and pulse echo_done_o in the first HOLDOFF cycle.
REQ-022 HOLDOFF SHALL last exactly HOLDOFF_CYC cycles, then go to IDLE.
REQ-023 Trigger activity in BURST, ECHO or HOLDOFF SHALL be ignored, with no error pulse.
REQ-024 A trigger still high when HOLDOFF ends SHALL NOT start a measurement; a fresh rising edge in IDLE is required.
REQ-025 Changes to echo_cycles_i after latching SHALL NOT affect the current pulse.
REQ-026 All counters SHALL be 32 bit; no wrap-around is permitted within any state.

Reset
REQ-027 While rst is high: state = IDLE, all counters 0, synchronizer flops 0, echo_o = busy_o = echo_done_o = short_trig_o = 0, asynchronously.
REQ-028 Reset asserted mid-ECHO SHALL drop echo_o immediately; after release, the block SHALL require a new trigger rising edge.

Configuration
REQ-029 With macro HCSR04_EMU_NOISE_EN defined, SHALL include a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advancing every cycle, and SHALL add its low 3 bits (0..7) to W after clamping.
REQ-030 Without HCSR04_EMU_NOISE_EN, no LFSR logic SHALL exist and the echo width SHALL equal W exactly.

Verification (TRIG_MIN_CYC=5, BURST_CYC=8, ECHO_MAX_CYC=100, HOLDOFF_CYC=20, noise off)
REQ-031 trig high 5 cycles, echo_cycles_i=40 -> echo_o rises 8 cycles after TRIG exit, stays high 40 cycles, echo_done_o pulses once, busy_o drops 20 cycles later.
REQ-032 trig high 4 cycles -> short_trig_o 1-cycle pulse, echo_o stays 0, busy_o stays 0.
REQ-033 echo_cycles_i=0, then separately echo_cycles_i=500 -> echo_o high exactly 100 cycles in each case.
REQ-034 second trig pulse (6 cycles) during ECHO, and trig held high through HOLDOFF end -> no extra echo; a new rising edge in IDLE produces a normal echo.
REQ-035 rst asserted 10 cycles into ECHO -> echo_o and busy_o go 0 same cycle; after release with trig low, nothing happens until the next valid trigger.
REQ-036 noise on, echo_cycles_i=40 -> echo width within 40..47 and matching the reference LFSR model.
